rtp_depacketizer: RTL

Receive-side counterpart of the team's RTP packetizer. Consumes a byte stream carrying one IPv4/UDP/RTP packet per frame, which is the byte order the packetizer emits. Validates the 20-byte IPv4, 8-byte UDP and 12-byte RTP headers, then streams the RTP payload out as bytes. Latches the RTP header fields per packet and flags malformed or out-of-sequence packets. Sits between the Ethernet/UDP receive path and the stream consumer.

---
 rtl/rtp_depacketizer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rtp_depacketizer.sv
// Receive-side IPv4/UDP/RTP parser: validates the 40-byte header stack,
// streams payload bytes and latches RTP header fields per good packet.
module rtp_depacketizer #(
    parameter logic [31:0] DEST_IP          = 32'h0A2A00FF,
    parameter logic [15:0] DEST_PORT        = 16'd2000,
    parameter logic [6:0]  PAYLOAD_TYPE     = 7'h1F,
    parameter logic [15:0] MAX_PACKET_BYTES = 16'd1500
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    input  logic        last_in,
    output logic [7:0]  payload_out,
    output logic        payload_valid_out,
    output logic        payload_last_out,
    output logic [15:0] rtp_seq_out,
    output logic [31:0] rtp_timestamp_out,
    output logic        rtp_marker_out,
    output logic [31:0] ssrc_out,
    output logic [15:0] payload_size_out,
    output logic        packet_done_out,
    output logic        packet_error_out,
    output logic        seq_gap_out
);

    typedef enum logic [2:0] {IDLE, IP_HDR, UDP_HDR, RTP_HDR, PAYLOAD, DROP} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] total_len;
    logic [15:0] last_idx;
    logic [15:0] len_now;
    logic [15:0] sh_seq;
    logic [31:0] sh_ts;
    logic [31:0] sh_ssrc;
    logic        sh_marker;
    logic        seq_armed;
    logic        in_hdr;
    logic        hdr_bad;

    assign last_idx = total_len - 16'd1;
    assign len_now  = {total_len[15:8], data_in};
    assign in_hdr   = (state == IDLE) || (state == IP_HDR) ||
                      (state == UDP_HDR) || (state == RTP_HDR);

    // cnt is the index of the byte currently on data_in (IDLE implies 0)
    always_comb begin
        hdr_bad = 1'b0;
        if (in_hdr) begin
            case (cnt)
                16'd0:   hdr_bad = (data_in != 8'h45);
                16'd3:   hdr_bad = (len_now < 16'd41) || (len_now > MAX_PACKET_BYTES);
                16'd9:   hdr_bad = (data_in != 8'h11);
                16'd16:  hdr_bad = (data_in != DEST_IP[31:24]);
                16'd17:  hdr_bad = (data_in != DEST_IP[23:16]);
                16'd18:  hdr_bad = (data_in != DEST_IP[15:8]);
                16'd19:  hdr_bad = (data_in != DEST_IP[7:0]);
                16'd22:  hdr_bad = (data_in != DEST_PORT[15:8]);
                16'd23:  hdr_bad = (data_in != DEST_PORT[7:0]);
                16'd28:  hdr_bad = (data_in[7:6] != 2'b10);
                16'd29:  hdr_bad = (data_in[6:0] != PAYLOAD_TYPE);
                default: hdr_bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            cnt               <= '0;
            total_len         <= '0;
            sh_seq            <= '0;
            sh_ts             <= '0;
            sh_ssrc           <= '0;
            sh_marker         <= 1'b0;
            seq_armed         <= 1'b0;
            payload_out       <= '0;
            payload_valid_out <= 1'b0;
            payload_last_out  <= 1'b0;
            rtp_seq_out       <= '0;
            rtp_timestamp_out <= '0;
            rtp_marker_out    <= 1'b0;
            ssrc_out          <= '0;
            payload_size_out  <= '0;
            packet_done_out   <= 1'b0;
            packet_error_out  <= 1'b0;
            seq_gap_out       <= 1'b0;
        end else begin
            payload_valid_out <= 1'b0;
            payload_last_out  <= 1'b0;
            packet_done_out   <= 1'b0;
            packet_error_out  <= 1'b0;
            seq_gap_out       <= 1'b0;
            if (valid_in) begin
                cnt <= cnt + 16'd1;
                if (in_hdr) begin
                    case (cnt)
                        16'd2:  total_len[15:8] <= data_in;
                        16'd3:  total_len[7:0]  <= data_in;
                        16'd29: sh_marker <= data_in[7];
                        16'd30, 16'd31: sh_seq <= {sh_seq[7:0], data_in};
                        16'd32, 16'd33, 16'd34, 16'd35: sh_ts <= {sh_ts[23:0], data_in};
                        16'd36, 16'd37, 16'd38, 16'd39: sh_ssrc <= {sh_ssrc[23:0], data_in};
                        default: ;
                    endcase
                    // total_len >= 41, so any last_in inside the header is early
                    if (last_in) begin
                        packet_error_out <= 1'b1;
                        state            <= IDLE;
                        cnt              <= '0;
                    end else if (hdr_bad) begin
                        state <= DROP;
                    end else if (cnt == 16'd19) begin
                        state <= UDP_HDR;
                    end else if (cnt == 16'd27) begin
                        state <= RTP_HDR;
                    end else if (cnt == 16'd39) begin
                        state <= PAYLOAD;
                    end else if (state == IDLE) begin
                        state <= IP_HDR;
                    end
                end else if (state == PAYLOAD) begin
                    payload_out       <= data_in;
                    payload_valid_out <= 1'b1;
                    if (cnt == last_idx) begin
                        if (last_in) begin
                            payload_last_out  <= 1'b1;
                            packet_done_out   <= 1'b1;
                            seq_gap_out       <= seq_armed && (sh_seq != rtp_seq_out + 16'd1);
                            seq_armed         <= 1'b1;
                            rtp_seq_out       <= sh_seq;
                            rtp_timestamp_out <= sh_ts;
                            rtp_marker_out    <= sh_marker;
                            ssrc_out          <= sh_ssrc;
                            payload_size_out  <= (total_len - 16'd40) << 3;
                            state             <= IDLE;
                            cnt               <= '0;
                        end else begin
                            state <= DROP;
                        end
                    end else if (last_in) begin
                        packet_error_out <= 1'b1;
                        state            <= IDLE;
                        cnt              <= '0;
                    end
                end else if (last_in) begin
                    packet_error_out <= 1'b1;
                    state            <= IDLE;
                    cnt              <= '0;
                end
            end
        end
    end

endmodule
